// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared definitions for the I2S slave receiver.
//   SAMPLE_W        - bits captured per channel word
//   i2s_rx_state_t  - receiver framing state
//   LR_LEFT/RIGHT   - word-select encoding (LrClk level per channel)
//   PIN_*           - bit positions of the external pins on the synchronizer bus
package i2s_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    SEEK,
    RX_L,
    RX_R
  } i2s_rx_state_t;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  localparam int PIN_BITCLK = 0;
  localparam int PIN_LRCLK  = 1;
  localparam int PIN_DATA   = 2;
  localparam int PIN_W      = 3;

endpackage

// File: rtl/i2s_pin_sync.sv
// i2s_pin_sync
// Multi-flop synchronizer for the external I2S pins plus a rising-edge
// detector on the synchronized bit clock. All pins go through the same
// depth, so LrClk and data are aligned with the bit clock at bitEdge.
// Ports:
//   CLK50MHZ   in   system clock
//   rst        in   asynchronous active-high reset
//   pinsAsync  in   {i2sData, LrClk, BitClk} straight from the pads
//   pinsSync   out  synchronized copy of pinsAsync
//   bitEdge    out  one-cycle strobe on a synchronized BitClk rising edge
import i2s_pkg::*;

module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = PIN_W
) (
  input  logic             CLK50MHZ,
  input  logic             rst,
  input  logic [WIDTH-1:0] pinsAsync,
  output logic [WIDTH-1:0] pinsSync,
  output logic             bitEdge
);

  logic [WIDTH-1:0] syncChain [SYNC_STAGES];
  logic             bitClkPrev;

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        syncChain[i] <= '0;
      end
      bitClkPrev <= 1'b0;
    end else begin
      syncChain[0] <= pinsAsync;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncChain[i] <= syncChain[i-1];
      end
      bitClkPrev <= syncChain[SYNC_STAGES-1][PIN_BITCLK];
    end
  end

  assign pinsSync = syncChain[SYNC_STAGES-1];
  assign bitEdge  = pinsSync[PIN_BITCLK] & ~bitClkPrev;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver
// I2S slave receiver: recovers 16-bit stereo samples (MSB first, one-bit
// delay after each LrClk transition, LrClk=0 is left) from an external
// stream that is asynchronous to CLK50MHZ, and publishes one left/right
// pair per frame.
// Ports:
//   CLK50MHZ     in   system clock, all logic on its rising edge
//   rst          in   asynchronous active-high reset
//   BitClk       in   external bit clock (async)
//   LrClk        in   external word select (async), 0 = left
//   i2sData      in   external serial data (async)
//   sampleL      out  last complete left word
//   sampleR      out  last complete right word
//   sampleValid  out  one-cycle pulse when a new pair is published
//   frameErr     out  one-cycle pulse on a short word
//   locked       out  high while aligned to LrClk transitions
//
// state | meaning
// ------+-------------------------------------------------------------
// SEEK  | not aligned; the next word end is discarded to find framing
// RX_L  | receiving a left word
// RX_R  | receiving a right word; a full word with leftOk publishes
import i2s_pkg::*;

module i2s_receiver #(
  parameter int SAMPLE_W       = i2s_pkg::SAMPLE_W,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK50MHZ,
  input  logic                rst,
  input  logic                BitClk,
  input  logic                LrClk,
  input  logic                i2sData,
  output logic [SAMPLE_W-1:0] sampleL,
  output logic [SAMPLE_W-1:0] sampleR,
  output logic                sampleValid,
  output logic                frameErr,
  output logic                locked
);

  // bitCnt runs 0..SAMPLE_W+1 (saturating) so long words stay distinguishable
  localparam int CNT_W = $clog2(SAMPLE_W + 2);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SAMPLE_W - 1);
  localparam logic [WD_W-1:0]  WD_LOAD   = WD_W'(TIMEOUT_CYCLES);

  logic [PIN_W-1:0] pinsSync;
  logic             bitEdge;
  logic             lrNow;
  logic             dataNow;

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (PIN_W)
  ) uPinSync (
    .CLK50MHZ (CLK50MHZ),
    .rst      (rst),
    .pinsAsync({i2sData, LrClk, BitClk}),
    .pinsSync (pinsSync),
    .bitEdge  (bitEdge)
  );

  assign lrNow   = pinsSync[PIN_LRCLK];
  assign dataNow = pinsSync[PIN_DATA];

  logic [SAMPLE_W-1:0] shiftReg;
  logic [SAMPLE_W-1:0] leftWord;
  logic [CNT_W-1:0]    bitCnt;
  logic [WD_W-1:0]     wdCnt;
  logic                lrPrev;
  logic                leftOk;

  i2s_rx_state_t state;
  i2s_rx_state_t stateNext;

  logic                wordEnd;
  logic                shiftEn;
  logic                wordFull;
  logic                wdExpire;
  logic [SAMPLE_W-1:0] wordNow;

  logic latchLeft;
  logic publish;
  logic errPulse;
  logic leftOkNext;

  // The bit taken on the word-end edge still belongs to the old word, so
  // wordNow already includes it when the FSM judges/latches the word.
  assign wordEnd  = bitEdge && (lrNow != lrPrev);
  assign shiftEn  = (bitCnt < CNT_SHIFT);
  assign wordNow  = shiftEn ? {shiftReg[SAMPLE_W-2:0], dataNow} : shiftReg;
  assign wordFull = (bitCnt >= CNT_FULL);

  // Down-counter reloaded on every bit edge; terminal count means the bit
  // clock has been silent for TIMEOUT_CYCLES. A bit edge always wins.
  assign wdExpire = (wdCnt == '0) && !bitEdge;

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      wdCnt <= '0;
    end else if (bitEdge) begin
      wdCnt <= WD_LOAD;
    end else if (wdCnt != '0) begin
      wdCnt <= wdCnt - 1'b1;
    end
  end

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      lrPrev   <= LR_LEFT;
    end else if (bitEdge) begin
      if (shiftEn) begin
        shiftReg <= wordNow;
      end
      if (wordEnd) begin
        bitCnt <= '0;
        lrPrev <= lrNow;
      end else if (bitCnt != CNT_SAT) begin
        bitCnt <= bitCnt + 1'b1;
      end
    end else if (wdExpire) begin
      bitCnt <= '0;
    end
  end

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      state <= SEEK;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    latchLeft  = 1'b0;
    publish    = 1'b0;
    errPulse   = 1'b0;
    leftOkNext = leftOk;
    if (wdExpire) begin
      stateNext  = SEEK;
      leftOkNext = 1'b0;
    end else if (wordEnd) begin
      case (state)
        SEEK: begin
          stateNext  = (lrNow == LR_LEFT) ? RX_L : RX_R;
          leftOkNext = 1'b0;
        end
        RX_L: begin
          if (wordFull) begin
            latchLeft  = 1'b1;
            leftOkNext = 1'b1;
          end else begin
            errPulse   = 1'b1;
            leftOkNext = 1'b0;
          end
          stateNext = RX_R;
        end
        RX_R: begin
          if (!wordFull) begin
            errPulse = 1'b1;
          end else if (leftOk) begin
            publish = 1'b1;
          end
          leftOkNext = 1'b0;
          stateNext  = RX_L;
        end
        default: begin
          stateNext  = SEEK;
          leftOkNext = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      leftOk      <= 1'b0;
      leftWord    <= '0;
      sampleL     <= '0;
      sampleR     <= '0;
      sampleValid <= 1'b0;
      frameErr    <= 1'b0;
    end else begin
      leftOk      <= leftOkNext;
      sampleValid <= publish;
      frameErr    <= errPulse;
      if (latchLeft) begin
        leftWord <= wordNow;
      end
      if (publish) begin
        sampleL <= leftWord;
        sampleR <= wordNow;
      end
    end
  end

  assign locked = (state != SEEK);

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
// Scoreboard bench for i2s_receiver. The stimulus side builds an I2S slot
// stream word by word; a word-level reference model decides, at each word
// end, whether a publish or a frame error is due and queues it. A monitor
// pops the queue whenever the DUT strobes sampleValid or frameErr.
module tb_i2s_receiver;
  import i2s_pkg::*;

  localparam int HALF_BIT = 355;  // BitClk half period; CLK50MHZ period is 20

  logic        CLK50MHZ = 1'b0;
  logic        rst      = 1'b1;
  logic        BitClk   = 1'b0;
  logic        LrClk    = 1'b0;
  logic        i2sData  = 1'b0;
  logic [15:0] sampleL;
  logic [15:0] sampleR;
  logic        sampleValid;
  logic        frameErr;
  logic        locked;

  i2s_receiver #(
    .SAMPLE_W      (16),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .CLK50MHZ   (CLK50MHZ),
    .rst        (rst),
    .BitClk     (BitClk),
    .LrClk      (LrClk),
    .i2sData    (i2sData),
    .sampleL    (sampleL),
    .sampleR    (sampleR),
    .sampleValid(sampleValid),
    .frameErr   (frameErr),
    .locked     (locked)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  typedef struct packed {
    logic        isValid;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t expQ[$];
  bit   slotLr[$];
  bit   slotD[$];
  bit   lastBit = 1'b0;

  int checks = 0;
  int passes = 0;

  // word-level reference model
  bit          haveOpen = 1'b0;
  bit          openCh;
  int          openN;
  logic [15:0] openVal;
  bit          mLocked = 1'b0;
  bit          mLeftOk = 1'b0;
  logic [15:0] mLeft   = '0;
  logic [15:0] mPubL   = '0;
  logic [15:0] mPubR   = '0;
  longint      lastRise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic modelWordEnd(input bit ch, input int n, input logic [15:0] v);
    exp_t e;
    if (!mLocked) begin
      mLocked = 1'b1;
      mLeftOk = 1'b0;
    end else if (ch == LR_LEFT) begin
      if (n >= 16) begin
        mLeft   = v;
        mLeftOk = 1'b1;
      end else begin
        e = '{isValid: 1'b0, l: 16'h0, r: 16'h0};
        expQ.push_back(e);
        mLeftOk = 1'b0;
      end
    end else begin
      if (n < 16) begin
        e = '{isValid: 1'b0, l: 16'h0, r: 16'h0};
        expQ.push_back(e);
      end else if (mLeftOk) begin
        e = '{isValid: 1'b1, l: mLeft, r: v};
        expQ.push_back(e);
        mPubL = mLeft;
        mPubR = v;
      end
      mLeftOk = 1'b0;
    end
  endtask

  // n slots on channel ch carrying v MSB first (zeros past 16 bits); data
  // lags LrClk by one slot. Same channel as the open word extends it.
  task automatic appendWord(input bit ch, input logic [15:0] v, input int n);
    if (haveOpen && openCh == ch) begin
      openN += n;
    end else begin
      if (haveOpen) modelWordEnd(openCh, openN, openVal);
      haveOpen = 1'b1;
      openCh   = ch;
      openN    = n;
      openVal  = v;
    end
    for (int i = 0; i < n; i++) begin
      slotLr.push_back(ch);
      slotD.push_back(lastBit);
      if (i < 16) lastBit = v[15-i];
      else        lastBit = 1'b0;
    end
  endtask

  task automatic appendFrame(input logic [15:0] l, input logic [15:0] r,
                             input int nl, input int nr);
    appendWord(LR_LEFT, l, nl);
    appendWord(LR_RIGHT, r, nr);
  endtask

  task automatic flush();
    while (slotLr.size() > 0) begin
      BitClk  = 1'b0;
      LrClk   = slotLr.pop_front();
      i2sData = slotD.pop_front();
      #HALF_BIT;
      BitClk   = 1'b1;
      lastRise = $time;
      #HALF_BIT;
    end
    repeat (8) @(posedge CLK50MHZ);
    check("drained", expQ.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge CLK50MHZ) begin
    exp_t e;
    if (!rst && (sampleValid || frameErr)) begin
      check("exclusive", {31'd0, sampleValid & frameErr}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        $display("FAIL unexpected: sampleValid=%0b frameErr=%0b with no event due", sampleValid, frameErr);
      end else begin
        e = expQ.pop_front();
        check("eventKind", {31'd0, sampleValid}, {31'd0, e.isValid});
        if (e.isValid) begin
          check("sampleL", {16'd0, sampleL}, {16'd0, e.l});
          check("sampleR", {16'd0, sampleR}, {16'd0, e.r});
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit     fell;
    longint fallT;
    int     elapsed;

    repeat (3) @(posedge CLK50MHZ);
    @(negedge CLK50MHZ);
    check("rstSampleL", {16'd0, sampleL}, 32'd0);
    check("rstSampleR", {16'd0, sampleR}, 32'd0);
    check("rstValid", {31'd0, sampleValid}, 32'd0);
    check("rstErr", {31'd0, frameErr}, 32'd0);
    check("rstLocked", {31'd0, locked}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge CLK50MHZ);

    // lock-up: first left word is discarded, lock comes on the first LrClk edge
    appendWord(LR_LEFT, 16'hA5C3, 16);
    flush();
    check("lockedBeforeEdge", {31'd0, locked}, 32'd0);
    appendWord(LR_RIGHT, 16'h1234, 16);
    flush();
    check("lockedAfterEdge", {31'd0, locked}, 32'd1);
    appendFrame(16'hA5C3, 16'h1234, 16, 16);

    // corner values
    appendFrame(16'h0001, 16'h8000, 16, 16);
    appendFrame(16'h7FFF, 16'hFFFF, 16, 16);
    appendFrame(16'h0000, 16'h5555, 16, 16);
    flush();

    // truncated left word then a normal frame
    appendFrame(16'hABCD, 16'h1111, 12, 16);
    appendFrame(16'h2222, 16'h3333, 16, 16);
    flush();

    // 24-bit slots: first 16 bits kept, trailing zeros ignored
    appendFrame(16'hBEEF, 16'hCAFE, 24, 24);
    appendFrame(16'h1357, 16'h2468, 16, 16);
    flush();

    // randomized frames, some with short or long slots
    for (int f = 0; f < 8; f++) begin
      appendFrame(16'($urandom), 16'($urandom),
                  int'($urandom_range(12, 24)), int'($urandom_range(12, 24)));
    end
    appendFrame(16'h0F0F, 16'hF0F0, 16, 16);
    appendWord(LR_LEFT, 16'h4321, 4);
    flush();

    // BitClk stall: lock drops after the timeout, outputs are held
    fell  = 1'b0;
    fallT = 0;
    repeat (300) begin
      @(negedge CLK50MHZ);
      if (!fell && !locked) begin
        fell  = 1'b1;
        fallT = $time;
      end
    end
    check("wdLockDropped", {31'd0, fell}, 32'd1);
    elapsed = int'((fallT - lastRise) / 20);
    checks++;
    if (fell && elapsed >= 254 && elapsed <= 262) passes++;
    else $display("FAIL wdLatency: got %0d cycles after last BitClk rise, expected 254..262", elapsed);
    check("wdHoldL", {16'd0, sampleL}, {16'd0, mPubL});
    check("wdHoldR", {16'd0, sampleR}, {16'd0, mPubR});
    mLocked = 1'b0;
    mLeftOk = 1'b0;

    appendWord(LR_LEFT, 16'h4321, 12);
    appendWord(LR_RIGHT, 16'h5555, 16);
    appendFrame(16'h6666, 16'h7777, 16, 16);
    appendFrame(16'h8888, 16'h9999, 16, 16);
    appendWord(LR_LEFT, 16'h1A2B, 16);
    appendWord(LR_RIGHT, 16'h3C4D, 8);
    flush();

    // reset in the middle of a right word
    @(posedge CLK50MHZ);
    rst = 1'b1;
    mLocked = 1'b0;
    mLeftOk = 1'b0;
    mPubL   = '0;
    mPubR   = '0;
    repeat (3) @(posedge CLK50MHZ);
    @(negedge CLK50MHZ);
    check("midRstSampleL", {16'd0, sampleL}, 32'd0);
    check("midRstSampleR", {16'd0, sampleR}, 32'd0);
    check("midRstValid", {31'd0, sampleValid}, 32'd0);
    check("midRstErr", {31'd0, frameErr}, 32'd0);
    check("midRstLocked", {31'd0, locked}, 32'd0);
    rst = 1'b0;

    appendWord(LR_RIGHT, 16'h3C4D, 20);
    appendFrame(16'h5A5A, 16'hA5A5, 16, 16);
    appendWord(LR_LEFT, 16'h0000, 4);
    flush();
    check("finalL", {16'd0, sampleL}, {16'd0, mPubL});
    check("finalR", {16'd0, sampleR}, {16'd0, mPubR});

    repeat (20) @(posedge CLK50MHZ);
    check("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
